spi_rx_buffer: RTL and testbench
================================

# spi_rx_buffer

Receive-side packet buffer sitting directly downstream of the SPI interface's receive memory port. It captures the byte writes the interface emits (address, data, write-enable) into an internal RAM. When the SPI transaction ends it commits them as one packet, then streams the packet out to the system over a valid/ready byte interface. Everything runs on SysClk; the receive-port signals and the end-of-transaction pulse arrive already synchronised to SysClk.

## Interface
- AddrBits, 12: RAM address width; capacity 2^AddrBits bytes.
- SysClk  in  1  system clock; all logic on its rising edge.
- Reset  in  1  synchronous, active-high; sampled on SysClk rising edge.
- rcMemAddr  in  AddrBits  write address from the SPI receive path.
- rcMemData  in  8  write data.
- rcMemWE  in  1  write strobe; one byte per cycle high.
- rcDone  in  1  single-cycle pulse: SPI_SS deasserted (transaction end).
- rdData  out  8  packet byte.
- rdValid  out  1  rdData valid.
- rdReady  in  1  consumer accepts byte when rdValid & rdReady.
- rdLast  out  1  high with the final byte of the packet.
- pktLen  out  AddrBits+1  length of committed packet; 0 when none.
- pktAvail  out  1  packet committed and not fully drained.
- overflow  out  1  sticky: a write was dropped while a packet was held.
- debug_out  out  8  last byte written (rcMemData of last accepted write).

## Operation
- States: IDLE (empty), FILL (≥1 byte written), PREFETCH, DRAIN.
- IDLE/FILL:
  - rcMemWE writes rcMemData to RAM[rcMemAddr].
  - Running length fillLen = max(fillLen, rcMemAddr+1), computed in AddrBits+1 bits, so addr 2^AddrBits−1 gives a full-size length without wrap.
  - The first write moves IDLE→FILL.
- rcDone in FILL: pktLen←fillLen, pktAvail←1, go to PREFETCH. rcDone in IDLE is ignored.
- rcMemWE and rcDone in the same cycle: the write is accepted and counted in pktLen.
- PREFETCH: RAM read of address 0 issued; go to DRAIN.
- DRAIN:
  - rdValid=1, rdData=RAM[idx], rdLast=(idx==pktLen−1).
  - On accept: idx←idx+1, with the next address read ahead so a continuous rdReady yields one byte per cycle.
  - Accept with rdLast: rdValid←0, pktAvail←0, pktLen←0, fillLen←0, idx←0, go to IDLE.
- While in PREFETCH/DRAIN: rcMemWE is dropped (RAM unchanged) and sets overflow; rcDone is ignored.
- overflow clears only on Reset.
- Holes: addresses never written within a packet read back whatever the RAM holds. No zeroing.

## Timing
- Reset values:
  - rdValid=0, rdLast=0, rdData=0, pktLen=0, pktAvail=0, overflow=0, debug_out=8'hFF, state=IDLE, fillLen=0, idx=0.
  - RAM contents are not reset.
- Reset mid-FILL or mid-DRAIN: the packet is discarded and all of the above are restored the next cycle.
- rcDone at cycle T:
  - pktAvail=1 and pktLen valid at T+1.
  - rdValid=1 with byte 0 at T+2.
- rdData/rdValid/rdLast change only on an accept or a state transition. They are held stable while rdValid & ~rdReady.
- An N-byte packet under constant rdReady drains in N cycles. The first write accepted in IDLE is at T_last+1 after the final accept.
- debug_out updates the cycle after each accepted write.

## Structure
- Package spi_pkg:
  - state encoding constants RX_IDLE/RX_FILL/RX_PREFETCH/RX_DRAIN;
  - default AddrBits;
  - debug_out reset value.
- Sub-module spi_rx_ram: simple dual-port RAM, 2^AddrBits×8, one write port, one registered read port with 1-cycle latency. Inferrable as block RAM.
- Top: FSM, fillLen/idx counters, read-ahead address mux, output registers.

## Test plan
- Bytes 0x01,0x02,0x03 at addr 0..2, rcDone, rdReady=1 -> pktLen=3 at T+1. rdData 0x01,0x02,0x03 on cycles T+2..T+4, rdLast on 0x03, pktAvail=0 at T+5.
- Write addr 5 only (0xAA), rcDone -> pktLen=6, rdLast on 6th byte = 0xAA; rcDone with no writes -> pktLen=0, rdValid stays 0.
- rdReady toggled 1,0,0,1 during drain -> rdData held during stalls, no byte skipped or repeated.
- Write during DRAIN (addr 0, 0x55) -> overflow=1, drained data unchanged. After the next packet, overflow is still 1.
- Write addr 2^AddrBits−1 plus rcDone in the same cycle -> pktLen=2^AddrBits, last byte equals that write.
- Reset asserted mid-DRAIN after 2 of 4 bytes -> next cycle all outputs at reset values. A new 1-byte packet then drains correctly.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared constants for the SPI receive packet buffer.
package spi_pkg;

  localparam int ADDR_BITS = 12;
  localparam logic [7:0] DEBUG_RST = 8'hFF;

  typedef enum logic [1:0] {
    RX_IDLE     = 2'd0,
    RX_FILL     = 2'd1,
    RX_PREFETCH = 2'd2,
    RX_DRAIN    = 2'd3
  } rx_state_e;

endpackage

// File: rtl/spi_rx_ram.sv
// Simple dual-port byte RAM: one write port, registered read port.
module spi_rx_ram #(
  parameter int AddrBits = 12
) (
  input  logic                clk_i,
  input  logic                we_i,
  input  logic [AddrBits-1:0] waddr_i,
  input  logic [7:0]          wdata_i,
  input  logic [AddrBits-1:0] raddr_i,
  output logic [7:0]          rdata_o
);

  logic [7:0] mem_q [2**AddrBits];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    rdata_o <= mem_q[raddr_i];
  end

endmodule

// File: rtl/spi_rx_buffer.sv
// Collects SPI receive-port writes into a packet and
// streams it out over a valid/ready byte interface.
module spi_rx_buffer
  import spi_pkg::*;
#(
  parameter int AddrBits = ADDR_BITS
) (
  input  logic                SysClk,
  input  logic                Reset,
  input  logic [AddrBits-1:0] rcMemAddr,
  input  logic [7:0]          rcMemData,
  input  logic                rcMemWE,
  input  logic                rcDone,
  output logic [7:0]          rdData,
  output logic                rdValid,
  input  logic                rdReady,
  output logic                rdLast,
  output logic [AddrBits:0]   pktLen,
  output logic                pktAvail,
  output logic                overflow,
  output logic [7:0]          debug_out
);

  localparam logic [AddrBits-1:0] ONE  = 1;
  localparam logic [AddrBits:0]   LONE = 1;

  rx_state_e state_q, state_d;

  logic [AddrBits:0]   fill_len_q, fill_len_d;
  logic [AddrBits:0]   pkt_len_q, pkt_len_d;
  logic [AddrBits-1:0] idx_q, idx_d;
  logic                ovf_q, ovf_d;
  logic [7:0]          dbg_q, dbg_d;

  logic                fill_ph, wr_ok, commit;
  logic                drain, last, accept;
  logic [AddrBits:0]   wr_len, len_max;
  logic [AddrBits-1:0] raddr;
  logic [7:0]          ram_rdata;

  assign fill_ph = (state_q == RX_IDLE) || (state_q == RX_FILL);
  assign wr_ok   = rcMemWE & fill_ph;
  assign wr_len  = {1'b0, rcMemAddr} + LONE;
  assign len_max = (wr_ok && (wr_len > fill_len_q)) ? wr_len : fill_len_q;
  // A write landing with rcDone counts, even straight from IDLE.
  assign commit  = rcDone && ((state_q == RX_FILL) || wr_ok);
  assign drain   = (state_q == RX_DRAIN);
  assign last    = drain && ({1'b0, idx_q} == (pkt_len_q - LONE));
  assign accept  = drain && rdReady;
  // Read ahead on accept so a steady rdReady streams one byte/cycle.
  assign raddr   = accept ? (idx_q + ONE) : idx_q;

  spi_rx_ram #(
    .AddrBits(AddrBits)
  ) u_ram (
    .clk_i  (SysClk),
    .we_i   (wr_ok),
    .waddr_i(rcMemAddr),
    .wdata_i(rcMemData),
    .raddr_i(raddr),
    .rdata_o(ram_rdata)
  );

  always_ff @(posedge SysClk) begin
    if (Reset) state_q <= RX_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RX_IDLE: begin
        if (commit)     state_d = RX_PREFETCH;
        else if (wr_ok) state_d = RX_FILL;
      end
      RX_FILL: begin
        if (commit) state_d = RX_PREFETCH;
      end
      RX_PREFETCH: state_d = RX_DRAIN;
      RX_DRAIN: begin
        if (accept && last) state_d = RX_IDLE;
      end
      default: state_d = RX_IDLE;
    endcase
  end

  always_comb begin
    fill_len_d = fill_len_q;
    pkt_len_d  = pkt_len_q;
    idx_d      = idx_q;
    ovf_d      = ovf_q | (rcMemWE & ~fill_ph);
    dbg_d      = wr_ok ? rcMemData : dbg_q;
    if (fill_ph) fill_len_d = len_max;
    if (commit)  pkt_len_d  = len_max;
    if (accept)  idx_d      = idx_q + ONE;
    if (accept && last) begin
      idx_d      = '0;
      pkt_len_d  = '0;
      fill_len_d = '0;
    end
  end

  always_ff @(posedge SysClk) begin
    if (Reset) begin
      fill_len_q <= '0;
      pkt_len_q  <= '0;
      idx_q      <= '0;
      ovf_q      <= 1'b0;
      dbg_q      <= DEBUG_RST;
    end else begin
      fill_len_q <= fill_len_d;
      pkt_len_q  <= pkt_len_d;
      idx_q      <= idx_d;
      ovf_q      <= ovf_d;
      dbg_q      <= dbg_d;
    end
  end

  always_comb begin
    rdValid   = drain;
    rdLast    = last;
    rdData    = drain ? ram_rdata : 8'h00;
    pktAvail  = (state_q == RX_PREFETCH) || drain;
    pktLen    = pkt_len_q;
    overflow  = ovf_q;
    debug_out = dbg_q;
  end

endmodule

// File: tb/tb_spi_rx_buffer.sv
// Directed bench for spi_rx_buffer.
module tb_spi_rx_buffer;

  localparam int AB = 12;

  logic          clk = 1'b0;
  logic          Reset = 1'b1;
  logic [AB-1:0] rcMemAddr = '0;
  logic [7:0]    rcMemData = '0;
  logic          rcMemWE = 1'b0;
  logic          rcDone = 1'b0;
  logic [7:0]    rdData;
  logic          rdValid;
  logic          rdReady = 1'b0;
  logic          rdLast;
  logic [AB:0]   pktLen;
  logic          pktAvail;
  logic          overflow;
  logic [7:0]    debug_out;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  spi_rx_buffer #(.AddrBits(AB)) dut (
    .SysClk   (clk),
    .Reset    (Reset),
    .rcMemAddr(rcMemAddr),
    .rcMemData(rcMemData),
    .rcMemWE  (rcMemWE),
    .rcDone   (rcDone),
    .rdData   (rdData),
    .rdValid  (rdValid),
    .rdReady  (rdReady),
    .rdLast   (rdLast),
    .pktLen   (pktLen),
    .pktAvail (pktAvail),
    .overflow (overflow),
    .debug_out(debug_out)
  );

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int a, input int d);
    rcMemAddr = AB'(a);
    rcMemData = 8'(d);
    rcMemWE = 1'b1;
    tick();
    rcMemWE = 1'b0;
  endtask

  task automatic done();
    rcDone = 1'b1;
    tick();
    rcDone = 1'b0;
  endtask

  task automatic chk_rst(input string tag);
    check({tag, " vld"}, 32'(rdValid), 0);
    check({tag, " last"}, 32'(rdLast), 0);
    check({tag, " data"}, 32'(rdData), 0);
    check({tag, " len"}, 32'(pktLen), 0);
    check({tag, " avail"}, 32'(pktAvail), 0);
    check({tag, " ovf"}, 32'(overflow), 0);
    check({tag, " dbg"}, 32'(debug_out), 'hFF);
  endtask

  // Called one cycle after rcDone; drains with rdReady held high.
  task automatic drain(input string tag, input int n,
                       input int b0, input int bl);
    int got;
    int cyc;
    int lastb;
    logic seen;
    got = 0;
    cyc = 0;
    lastb = 0;
    seen = 1'b0;
    rdReady = 1'b1;
    while (!seen && cyc < n + 10) begin
      tick();
      cyc++;
      if (rdValid) begin
        if (got == 0) check({tag, " b0"}, 32'(rdData), b0);
        got++;
        lastb = 32'(rdData);
        seen = rdLast;
      end
    end
    check({tag, " n"}, got, n);
    check({tag, " lastb"}, lastb, bl);
    tick();
    check({tag, " end"}, 32'({rdValid, pktAvail}), 0);
  endtask

  initial begin
    tick();
    tick();
    Reset = 1'b0;
    chk_rst("rst");

    rdReady = 1'b1;
    wr(0, 'h01);
    wr(1, 'h02);
    wr(2, 'h03);
    check("dbg", 32'(debug_out), 'h03);
    done();
    check("p1 len", 32'(pktLen), 3);
    check("p1 avail", 32'(pktAvail), 1);
    check("p1 vld0", 32'(rdValid), 0);
    tick();
    check("p1 d0", 32'({rdValid, rdLast, rdData}), 'h201);
    tick();
    check("p1 d1", 32'({rdValid, rdLast, rdData}), 'h202);
    tick();
    check("p1 d2", 32'({rdValid, rdLast, rdData}), 'h303);
    tick();
    check("p1 end", 32'({rdValid, pktAvail}), 0);
    check("p1 len0", 32'(pktLen), 0);

    wr(5, 'hAA);
    done();
    check("p2 len", 32'(pktLen), 6);
    drain("p2", 6, 'h01, 'hAA);
    done();
    check("empty len", 32'(pktLen), 0);
    tick();
    check("empty vld", 32'({rdValid, pktAvail}), 0);

    wr(0, 'h10);
    wr(1, 'h20);
    wr(2, 'h30);
    wr(3, 'h40);
    done();
    tick();
    check("st d0", 32'(rdData), 'h10);
    tick();
    check("st d1", 32'(rdData), 'h20);
    rdReady = 1'b0;
    tick();
    check("st hold1", 32'({rdValid, rdData}), 'h120);
    tick();
    check("st hold2", 32'({rdValid, rdData}), 'h120);
    rdReady = 1'b1;
    tick();
    check("st d2", 32'({rdLast, rdData}), 'h030);
    tick();
    check("st d3", 32'({rdLast, rdData}), 'h140);
    tick();
    check("st end", 32'(rdValid), 0);

    wr(0, 'h61);
    wr(1, 'h62);
    done();
    rdReady = 1'b0;
    tick();
    check("ov d0", 32'(rdData), 'h61);
    rcMemAddr = '0;
    rcMemData = 8'h55;
    rcMemWE = 1'b1;
    tick();
    rcMemWE = 1'b0;
    check("ov flag", 32'(overflow), 1);
    check("ov dbg", 32'(debug_out), 'h62);
    tick();
    check("ov keep", 32'(rdData), 'h61);
    rdReady = 1'b1;
    tick();
    check("ov d1", 32'({rdLast, rdData}), 'h162);
    tick();
    check("ov end", 32'(rdValid), 0);
    wr(0, 'h77);
    done();
    drain("p5", 1, 'h77, 'h77);
    check("ov sticky", 32'(overflow), 1);

    wr(0, 'h11);
    rcMemAddr = AB'((1 << AB) - 1);
    rcMemData = 8'hC3;
    rcMemWE = 1'b1;
    rcDone = 1'b1;
    tick();
    rcMemWE = 1'b0;
    rcDone = 1'b0;
    check("full len", 32'(pktLen), 1 << AB);
    drain("full", 1 << AB, 'h11, 'hC3);

    wr(0, 'hA1);
    wr(1, 'hA2);
    wr(2, 'hA3);
    wr(3, 'hA4);
    done();
    tick();
    tick();
    tick();
    check("mid d2", 32'(rdData), 'hA3);
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    chk_rst("mrst");
    wr(0, 'h5A);
    done();
    check("one len", 32'(pktLen), 1);
    drain("one", 1, 'h5A, 'h5A);
    check("one dbg", 32'(debug_out), 'h5A);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
